// File: rtl/microstore_ram.sv
// microstore_ram: writable, registered control store with valid bitmap and fallback word.
// Revision 1.0
`default_nettype none

module microstore_ram #(
  parameter int unsigned          WORD_W      = 45,
  parameter int unsigned          ADDR_W      = 7,
  parameter int unsigned          DEPTH       = 128,
  parameter logic [WORD_W-1:0]    RESET_WORD  = 45'b001001100000000000000000000001000000000100001,
  parameter logic [ADDR_W-1:0]    RESET_STATE = '0,
  parameter int unsigned          CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_state,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              inv_all,
  output logic [WORD_W-1:0] signals_out,
  output logic [ADDR_W-1:0] active_state,
  output logic              out_valid,
  output logic              miss,
  output logic              wr_err,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [WORD_W-1:0] signals_q, signals_d;
  logic [ADDR_W-1:0] state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic              miss_q, miss_d;
  logic              wr_err_q, wr_err_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic              wr_in_range, rd_in_range, wr_ok, bypass, rd_hit;
  logic [WORD_W-1:0] rd_word;

  assign wr_in_range = {1'b0, wr_addr}  < C_DEPTH;
  assign rd_in_range = {1'b0, rd_state} < C_DEPTH;
  assign wr_ok       = wr_en & ~inv_all & wr_in_range;
  // Write-first: a same-cycle write to the read address forwards its data.
  assign bypass      = wr_ok & (wr_addr == rd_state);
  assign rd_hit      = ~inv_all & rd_in_range & (bypass | valid_q[rd_state]);
  assign rd_word     = bypass ? wr_data : mem_q[rd_state];

  always_comb begin
    valid_d     = valid_q;
    signals_d   = signals_q;
    state_d     = state_q;
    out_valid_d = 1'b0;
    miss_d      = 1'b0;
    wr_err_d    = wr_en & ~wr_ok;
    miss_cnt_d  = miss_cnt_q;
    if (inv_all) begin
      valid_d = '0;
    end else if (wr_ok) begin
      valid_d[wr_addr] = 1'b1;
    end
    if (rd_en) begin
      out_valid_d = 1'b1;
      if (rd_hit) begin
        signals_d = rd_word;
        state_d   = rd_state;
      end else begin
        signals_d = RESET_WORD;
        state_d   = RESET_STATE;
        miss_d    = 1'b1;
        if (miss_cnt_q != '1) begin
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      signals_q   <= RESET_WORD;
      state_q     <= RESET_STATE;
      out_valid_q <= 1'b0;
      miss_q      <= 1'b0;
      wr_err_q    <= 1'b0;
      miss_cnt_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      signals_q   <= signals_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      miss_q      <= miss_d;
      wr_err_q    <= wr_err_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Array contents survive reset; only the valid bitmap is cleared.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign signals_out  = signals_q;
  assign active_state = state_q;
  assign out_valid    = out_valid_q;
  assign miss         = miss_q;
  assign wr_err       = wr_err_q;
  assign miss_cnt     = miss_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_microstore_ram.sv
// Self-checking bench for microstore_ram: directed cases plus randomized traffic against a reference model.
`default_nettype none

module tb_microstore_ram;

  localparam int          WORD_W = 45;
  localparam int          ADDR_W = 7;
  localparam int          DEPTH  = 24;
  localparam int          CNT_W  = 2;
  localparam logic [44:0] RW     = 45'b001001100000000000000000000001000000000100001;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_state = '0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [WORD_W-1:0] wr_data = '0;
  logic              inv_all = 1'b0;
  logic [WORD_W-1:0] signals_out;
  logic [ADDR_W-1:0] active_state;
  logic              out_valid, miss, wr_err;
  logic [CNT_W-1:0]  miss_cnt;

  microstore_ram #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_state(rd_state),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .inv_all(inv_all),
    .signals_out(signals_out), .active_state(active_state), .out_valid(out_valid),
    .miss(miss), .wr_err(wr_err), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [44:0] m_mem [DEPTH];
  bit          m_val [DEPTH];
  logic [44:0] e_sig;
  int          e_state, e_cnt;
  bit          e_ov, e_miss, e_werr;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit rd, input int rs, input bit we, input int wa,
                      input logic [44:0] wd, input bit inv);
    bit write_ok;
    reset = rst; rd_en = rd; rd_state = rs[ADDR_W-1:0];
    wr_en = we; wr_addr = wa[ADDR_W-1:0]; wr_data = wd; inv_all = inv;
    @(posedge clk);
    #1;
    if (rst) begin
      e_sig = RW; e_state = 0; e_ov = 0; e_miss = 0; e_werr = 0; e_cnt = 0;
      for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
    end else begin
      write_ok = we && !inv && wa < DEPTH;
      e_werr = we && !write_ok;
      e_ov = rd;
      e_miss = 0;
      if (rd) begin
        if (!inv && rs < DEPTH && write_ok && wa == rs) begin
          e_sig = wd; e_state = rs;
        end else if (!inv && rs < DEPTH && m_val[rs]) begin
          e_sig = m_mem[rs]; e_state = rs;
        end else begin
          e_sig = RW; e_state = 0; e_miss = 1;
          if (e_cnt < (1 << CNT_W) - 1) e_cnt++;
        end
      end
      if (inv) begin
        for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
      end else if (write_ok) begin
        m_mem[wa] = wd; m_val[wa] = 1;
      end
    end
    check_val("signals_out", 64'(signals_out), 64'(e_sig));
    check_val("active_state", 64'(active_state), 64'(e_state));
    check_val("out_valid", 64'(out_valid), 64'(e_ov));
    check_val("miss", 64'(miss), 64'(e_miss));
    check_val("wr_err", 64'(wr_err), 64'(e_werr));
    check_val("miss_cnt", 64'(miss_cnt), 64'(e_cnt));
  endtask

  initial begin
    int sat_exp [5] = '{1, 2, 3, 3, 3};

    step(1, 0, 0, 0, 0, '0, 0);
    step(1, 0, 0, 0, 0, '0, 0);

    // Unwritten state misses and falls back.
    step(0, 1, 5, 0, 0, '0, 0);
    check_val("first_miss_cnt", 64'(miss_cnt), 64'd1);

    step(0, 0, 0, 1, 1, 45'h0C0_0800_0003, 0);
    step(0, 1, 1, 0, 0, '0, 0);
    check_val("readback", 64'(signals_out), 64'h0C0_0800_0003);

    step(0, 1, 2, 1, 2, 45'h1234, 0);
    check_val("write_first", 64'(signals_out), 64'h1234);

    step(0, 0, 0, 1, 30, 45'h1FFF, 0);
    check_val("wr_oob_err", 64'(wr_err), 64'd1);
    step(0, 1, 30, 0, 0, '0, 0);
    check_val("rd_oob_miss", 64'(miss), 64'd1);

    step(0, 0, 0, 1, 3, 45'h5A5A, 0);
    step(0, 0, 0, 1, 4, 45'h777, 1);
    step(0, 1, 3, 0, 0, '0, 0);
    step(0, 1, 4, 0, 0, '0, 0);
    step(0, 1, 23, 1, 23, 45'h1_0000_0001, 0);
    step(0, 1, 24, 1, 24, 45'h2, 0);

    step(1, 1, 3, 1, 3, 45'h99, 1);
    check_val("reset_cnt", 64'(miss_cnt), 64'd0);

    for (int i = 0; i < 5; i++) begin
      step(0, 1, 30, 0, 0, '0, 0);
      check_val("sat_cnt", 64'(miss_cnt), 64'(sat_exp[i]));
    end

    step(1, 0, 0, 0, 0, '0, 0);
    for (int i = 0; i < 500; i++) begin
      bit          r_rst, r_rd, r_we, r_inv;
      int          r_rs, r_wa;
      logic [44:0] r_wd;
      r_rst = ($urandom_range(0, 99) < 2);
      r_rd  = ($urandom_range(0, 99) < 70);
      r_we  = ($urandom_range(0, 99) < 50);
      r_inv = ($urandom_range(0, 99) < 3);
      r_rs  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 27);
      r_wa  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 27);
      r_wd  = {13'($urandom), 32'($urandom)};
      step(r_rst, r_rd, r_rs, r_we, r_wa, r_wd, r_inv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
